cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Upstream control stage for the 16-bit datapath. Holds the instruction register (IR),
//  decodes Simple-RISC ALU/MOV instructions and sequences a Moore FSM that drives every
//  datapath control input (readnum, writenum, vsel, loada/b/c, loads, asel, bsel, shift,
//  ALUop, write, sximm5, sximm8). Signals completion to the outside world on w.
// PARAMETERS
//  IW   16  instruction and datapath word width
//  RW   3   register-number width
// PORTS
//  clk       in   1   rising-edge clock; sole clock
//  reset_n   in   1   synchronous, active-low reset
//  in        in   IW  instruction word
//  load      in   1   IR load strobe; honoured only in WAIT
//  s         in   1   start execution; sampled only in WAIT
//  w         out  1   1 iff state==WAIT (idle, ready)
//  readnum   out  RW  regfile read address
//  writenum  out  RW  regfile write address
//  write     out  1   regfile write enable
//  vsel      out  2   00=C 01=PC 10=sximm8 11=mdata
//  loada/loadb/loadc/loads  out 1 each  datapath register enables
//  asel      out  1   1 selects 16'b0 for Ain
//  bsel      out  1   1 selects sximm5 for Bin
//  shift     out  2   shifter op (IR[4:3] in ALU state, else 00)
//  ALUop     out  2   ALU op
//  sximm8    out  IW  sign-extended IR[7:0], continuous
//  sximm5    out  IW  sign-extended IR[4:0], continuous
//  err       out  1   illegal-instruction flag (ILLEGAL_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  IR fields: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0].
//  Reset (reset_n=0 at edge): state=WAIT, IR=0, err=0; outputs then w=1, all enables/write=0,
//   vsel=00, asel=bsel=0, shift=00, ALUop=00, readnum=writenum=0.
//  All control outputs are Moore decode of state+IR. Default in every state: all 0.
//  WAIT: load=1 -> IR<=in. s=1 -> DECODE. Both high same cycle: new IR executes.
//  load in any non-WAIT state is ignored (IR frozen for in-flight instruction).
//  DECODE: 110/10 MOV imm ->WRITE_IMM; 110/00 MOV reg, 101/11 MVN ->GET_B;
//   101/00 ADD, 101/01 CMP, 101/10 AND ->GET_A; anything else -> illegal handling.
//  GET_A: readnum=Rn, loada=1 -> GET_B.  GET_B: readnum=Rm, loadb=1 -> ALU.
//  ALU: shift=sh, bsel=0; MOV reg: asel=1, ALUop=00; MVN: asel=1, ALUop=11;
//   ADD/AND: asel=0, ALUop=op, loadc=1 -> WRITE_REG; CMP: asel=0, ALUop=01, loads=1,
//   loadc=0 -> WAIT. MOV reg/MVN also loadc=1 -> WRITE_REG.
//  WRITE_REG: writenum=Rd, vsel=00, write=1 -> WAIT.
//  WRITE_IMM: writenum=Rn, vsel=10, write=1 -> WAIT.
//  Latency s-edge to w=1: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6 cycles.
//  write asserts for exactly one cycle per writing instruction; never for CMP.
//  Reset mid-instruction: next edge WAIT, no further enables/writes issued.
// CONFIGURATION
//  `ILLEGAL_TRAP_EN defined: illegal opcode -> HALT; err=1, w=0, all enables 0; only
//   reset_n=0 exits. Undefined: illegal opcode -> WAIT next edge as NOP, err tied 0.
// STRUCTURE
//  Package cpu_pkg: state typedef/encoding, opcode/op constants, vsel codes.
//  Sub-module instr_decoder: combinational field extract + sign extension of IR.
//  FSM + IR register remain in cpu_ctrl_fsm.
// TESTING
//  1 reset_n=0 one edge mid-idle -> w=1, write=0, loada..loads=0, IR=0.
//  2 in=0xD1FE load+s -> DECODE, WRITE_IMM(write=1, writenum=1, vsel=10, sximm8=0xFFFE), w=1 3rd edge.
//  3 in=0xA148 (ADD R2,R1,R0,LSL#1) -> GET_A rd=1 loada; GET_B rd=0 loadb; ALU shift=01
//    ALUop=00 loadc; WRITE_REG wn=2 vsel=00 write; w=1 6th edge.
//  4 in=0xA900 (CMP R1,R0) -> ALU state loads=1, loadc=0; write never 1; w=1 5th edge.
//  5 reset_n=0 during GET_B of 0xA148 -> WAIT next edge, write never pulses; load=1 in
//    GET_A with in=0xD007 -> IR unchanged.
//  6 in=0xE000: trap build -> err=1, w=0 held 10 cycles until reset; non-trap -> w=1 after 2 edges.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple-RISC control stage.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes halt the FSM).
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_WRITE_IMM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    I_MOVI,
    I_MOVR,
    I_MVN,
    I_ADD,
    I_CMP,
    I_AND,
    I_ILL
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  function automatic iclass_t classify(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    iclass_t c;
    c = I_ILL;
    unique case (1'b1)
      (opc == OPC_MOV && op == OP_MOVI): c = I_MOVI;
      (opc == OPC_MOV && op == OP_MOVR): c = I_MOVR;
      (opc == OPC_ALU && op == OP_MVN):  c = I_MVN;
      (opc == OPC_ALU && op == OP_ADD):  c = I_ADD;
      (opc == OPC_ALU && op == OP_CMP):  c = I_CMP;
      (opc == OPC_ALU && op == OP_AND):  c = I_AND;
      default:                           c = I_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_instr_decoder.sv
// Combinational IR field extraction, classification and
// immediate sign extension.
import cpu_pkg::*;

module instr_decoder #(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic [IW-1:0] i_ir,
  output iclass_t       o_cls,
  output logic [1:0]    o_op,
  output logic [RW-1:0] o_rn,
  output logic [RW-1:0] o_rd,
  output logic [1:0]    o_sh,
  output logic [RW-1:0] o_rm,
  output logic [IW-1:0] o_sximm5,
  output logic [IW-1:0] o_sximm8
);

  logic [2:0] w_opc;

  assign w_opc    = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_cls    = classify(w_opc, o_op);
  assign o_sximm5 = {{(IW-5){i_ir[4]}}, i_ir[4:0]};
  assign o_sximm8 = {{(IW-8){i_ir[7]}}, i_ir[7:0]};

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Control stage: IR register plus Moore sequencer for the datapath.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode -> HALT, err=1).
import cpu_pkg::*;

module cpu_ctrl_fsm #(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5,
  output logic          err
);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ir;

  iclass_t       w_cls;
  logic [1:0]    w_op;
  logic [RW-1:0] w_rn;
  logic [RW-1:0] w_rd;
  logic [1:0]    w_sh;
  logic [RW-1:0] w_rm;

  instr_decoder #(
    .IW(IW),
    .RW(RW)
  ) u_dec (
    .i_ir    (r_ir),
    .o_cls   (w_cls),
    .o_op    (w_op),
    .o_rn    (w_rn),
    .o_rd    (w_rd),
    .o_sh    (w_sh),
    .o_rm    (w_rm),
    .o_sximm5(sximm5),
    .o_sximm8(sximm8)
  );

  // IR only changes while idle so an in-flight instruction is stable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) begin
        r_ir <= in;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT: begin
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (w_cls)
          I_MOVI:        w_next = S_WRITE_IMM;
          I_MOVR, I_MVN: w_next = S_GET_B;
          I_ADD, I_CMP,
          I_AND:         w_next = S_GET_A;
`ifdef ILLEGAL_TRAP_EN
          default:       w_next = S_HALT;
`else
          default:       w_next = S_WAIT;
`endif
        endcase
      end
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_ALU;
      S_ALU: begin
        if (w_cls == I_CMP) w_next = S_WAIT;
        else                w_next = S_WRITE_REG;
      end
      S_WRITE_REG: w_next = S_WAIT;
      S_WRITE_IMM: w_next = S_WAIT;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:      w_next = S_HALT;
`endif
      default:     w_next = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    err      = 1'b0;
    unique case (r_state)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = w_sh;
        unique case (w_cls)
          I_MOVR: begin
            asel  = 1'b1;
            ALUop = ALU_ADD;
            loadc = 1'b1;
          end
          I_MVN: begin
            asel  = 1'b1;
            ALUop = ALU_NOT;
            loadc = 1'b1;
          end
          I_CMP: begin
            ALUop = ALU_SUB;
            loads = 1'b1;
          end
          default: begin
            ALUop = w_op;
            loadc = 1'b1;
          end
        endcase
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-instruction output
// scripts from the ISA rules plus directed literal checks.
module tb_cpu_ctrl_fsm;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        err;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .s       (s),
    .w       (w),
    .readnum (readnum),
    .writenum(writenum),
    .write   (write),
    .vsel    (vsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .bsel    (bsel),
    .shift   (shift),
    .ALUop   (ALUop),
    .sximm8  (sximm8),
    .sximm5  (sximm5),
    .err     (err)
  );

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic [1:0] vsel;
    logic       la;
    logic       lb;
    logic       lc;
    logic       ls;
    logic       asel;
    logic       bsel;
    logic [1:0] sh;
    logic [1:0] aop;
  } ctl_t;

  ctl_t        q[$];
  logic [15:0] m_ir;
  bit          halted;
  bit          pend_halt;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          wcnt = 0;
  int          lscnt = 0;
  logic [2:0]  last_wn;
  logic [1:0]  last_vs;
  logic [15:0] last_sx8;
  logic [1:0]  last_sh;
  logic [1:0]  last_aop;

  // Script of expected per-cycle outputs from DECODE onwards
  function automatic void start(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] op;
    ctl_t d, ga, gb, al, wr;
    opc = ir[15:13];
    op  = ir[12:11];
    d  = '0;
    ga = '0; ga.rn = ir[10:8]; ga.la = 1'b1;
    gb = '0; gb.rn = ir[2:0];  gb.lb = 1'b1;
    al = '0; al.sh = ir[4:3];
    wr = '0; wr.wn = ir[7:5];  wr.wr = 1'b1;
    q.delete();
    q.push_back(d);
    if (opc == 3'd6 && op == 2'd2) begin
      wr.wn = ir[10:8];
      wr.vsel = 2'd2;
      q.push_back(wr);
    end else if ((opc == 3'd6 && op == 2'd0) ||
                 (opc == 3'd5 && op == 2'd3)) begin
      al.asel = 1'b1;
      al.aop = (op == 2'd3) ? 2'd3 : 2'd0;
      al.lc = 1'b1;
      q.push_back(gb);
      q.push_back(al);
      q.push_back(wr);
    end else if (opc == 3'd5 && op == 2'd1) begin
      al.aop = 2'd1;
      al.ls = 1'b1;
      q.push_back(ga);
      q.push_back(gb);
      q.push_back(al);
    end else if (opc == 3'd5 && (op == 2'd0 || op == 2'd2)) begin
      al.aop = op;
      al.lc = 1'b1;
      q.push_back(ga);
      q.push_back(gb);
      q.push_back(al);
      q.push_back(wr);
    end else begin
      pend_halt = TRAP;
    end
  endfunction

  function automatic ctl_t expect_now();
    ctl_t c;
    c = '0;
    if (q.size() != 0) c = q[0];
    else if (halted) c.err = 1'b1;
    else c.w = 1'b1;
    return c;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      halted = 1'b0;
      pend_halt = 1'b0;
      m_ir = '0;
    end else if (halted) begin
    end else if (q.size() != 0) begin
      void'(q.pop_front());
      if (q.size() == 0 && pend_halt) begin
        halted = 1'b1;
        pend_halt = 1'b0;
      end
    end else begin
      if (load) m_ir = in;
      if (s) start(m_ir);
    end
  end

  always @(negedge clk) begin
    ctl_t a, e;
    logic [15:0] e8, e5;
    if (chk_en) begin
      a.w = w; a.err = err; a.rn = readnum; a.wn = writenum;
      a.wr = write; a.vsel = vsel; a.la = loada; a.lb = loadb;
      a.lc = loadc; a.ls = loads; a.asel = asel; a.bsel = bsel;
      a.sh = shift; a.aop = ALUop;
      e = expect_now();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctl t=%0t got %h want %h", $time, a, e);
      end
      e8 = 16'(int'($signed(m_ir[7:0])));
      e5 = 16'(int'($signed(m_ir[4:0])));
      n_chk++;
      if ({sximm8, sximm5} !== {e8, e5}) begin
        n_fail++;
        $display("FAIL sximm t=%0t got %h/%h want %h/%h",
                 $time, sximm8, sximm5, e8, e5);
      end
    end
    if (write === 1'b1) begin
      wcnt++;
      last_wn = writenum;
      last_vs = vsel;
      last_sx8 = sximm8;
    end
    if (loadc === 1'b1) begin
      last_sh = shift;
      last_aop = ALUop;
    end
    if (loads === 1'b1) lscnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic run(input logic [15:0] ins, input int lat,
                     input string nm);
    int n;
    in = ins; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    n = 1;
    while (w !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, lat);
  endtask

  initial begin : main
    logic [15:0] r;
    reset_n = 1'b0; load = 1'b0; s = 1'b0; in = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    in = 16'hD1FE; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    chk("ir_loaded_sx8", sximm8, 16'hFFFE);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("rst_w", w, 1);
    chk("rst_write", write, 0);
    chk("rst_loads", {loada, loadb, loadc, loads}, 0);
    chk("rst_ir", sximm8, 0);

    wcnt = 0;
    run(16'hD1FE, 3, "lat_movi");
    chk("movi_wcnt", wcnt, 1);
    chk("movi_wn", last_wn, 1);
    chk("movi_vsel", last_vs, 2);
    chk("movi_sx8", last_sx8, 16'hFFFE);

    wcnt = 0;
    run(16'hA148, 6, "lat_add");
    chk("add_wcnt", wcnt, 1);
    chk("add_wn", last_wn, 2);
    chk("add_vsel", last_vs, 0);
    chk("add_shift", last_sh, 1);
    chk("add_aluop", last_aop, 0);

    wcnt = 0; lscnt = 0;
    run(16'hA900, 5, "lat_cmp");
    chk("cmp_wcnt", wcnt, 0);
    chk("cmp_loads", lscnt, 1);

    wcnt = 0;
    run(16'hB800, 5, "lat_mvn");
    chk("mvn_wcnt", wcnt, 1);
    chk("mvn_aluop", last_aop, 3);

    wcnt = 0;
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1 load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    chk("geta_loada", loada, 1);
    in = 16'hD007; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    chk("frozen_sx8", sximm8, 16'h0048);
    chk("frozen_sx5", sximm5, 16'h0008);
    chk("getb_loadb", loadb, 1);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("midrst_w", w, 1);
    repeat (3) @(posedge clk);
    #1 chk("midrst_wcnt", wcnt, 0);

    if (TRAP) begin
      in = 16'hE000; load = 1'b1; s = 1'b1;
      @(posedge clk); #1 load = 1'b0; s = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("trap_err", err, 1);
      chk("trap_w", w, 0);
      reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      chk("trap_exit", {w, err}, 2'b10);
    end else begin
      run(16'hE000, 2, "lat_illegal");
      chk("nop_err", err, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      case ($urandom % 8)
        0: r[15:11] = 5'b11010;
        1: r[15:11] = 5'b11000;
        2: r[15:11] = 5'b10111;
        3: r[15:11] = 5'b10100;
        4: r[15:11] = 5'b10101;
        5: r[15:11] = 5'b10110;
        6: r[15:11] = 5'b10100;
        default: ;
      endcase
      in = r;
      load = ($urandom % 3) == 0;
      s = ($urandom % 2) == 0;
      reset_n = ($urandom % 64) != 0;
      @(posedge clk); #1;
    end
    reset_n = 1'b1; load = 1'b0; s = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
